// File: rtl/vram_host_ctrl.sv
// rtl/vram_host_ctrl.sv - host byte-write FIFO with auto-increment pointer, drained into screen RAM during blanking
module vram_host_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int GUARD    = 8,
  parameter int DEPTH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_cs,
  input  logic        host_we,
  input  logic [1:0]  host_rs,
  input  logic [7:0]  host_din,
  output logic [7:0]  host_dout,
  input  logic [9:0]  posx,
  input  logic [8:0]  posy,
  input  logic [12:0] disp_addr,
  output logic [12:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        fifo_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [9:0]    X_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0]    X_GUARD = 10'(H_TOTAL - GUARD);
  localparam logic [8:0]    Y_ACT   = 9'(V_ACTIVE);
  localparam logic [8:0]    Y_LAST  = 9'(V_TOTAL - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [12:0]   ptr_q, ptr_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [20:0]   fifo_q [DEPTH];
  logic [20:0]   fifo_d [DEPTH];
  logic [12:0]   waddr_q, waddr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    dout_q, dout_d;

  logic wr_acc, rd_acc, full, empty, push, pop, flush, win;

  assign wr_acc = host_cs & host_we;
  assign rd_acc = host_cs & ~host_we;
  assign full   = (cnt_q == CNT_FULL);
  assign empty  = (cnt_q == '0);
  assign push   = wr_acc && (host_rs == 2'd2) && !full;
  assign flush  = wr_acc && (host_rs == 2'd3) && host_din[0];

  // Window closes GUARD pixels early so the final write retires before the renderer resumes
  assign win = ((posx >= X_ACT) && (posx < X_GUARD) && (posy < Y_ACT)) ||
               ((posy >= Y_ACT) && !((posy == Y_LAST) && (posx >= X_GUARD)));
  assign pop = win && !empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = pop ? WRITE : IDLE;
      WRITE:   state_d = pop ? WRITE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = (state_q == WRITE);
    mem_addr  = mem_we ? waddr_q : disp_addr;
    mem_din   = wdata_q;
    host_dout = dout_q;
    fifo_full = full;
  end

  always_comb begin
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    fifo_d  = fifo_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;

    if (rd_acc) begin
      case (host_rs)
        2'd0:    dout_d = ptr_q[7:0];
        2'd1:    dout_d = {3'b000, ptr_q[12:8]};
        2'd2:    dout_d = 8'h00;
        default: dout_d = {5'b00000, ovf_q, full, empty};
      endcase
    end

    if (wr_acc) begin
      case (host_rs)
        2'd0:    ptr_d[7:0]  = host_din;
        2'd1:    ptr_d[12:8] = host_din[4:0];
        2'd2:    if (full) ovf_d = 1'b1;
                 else      ptr_d = ptr_q + 13'd1;
        default: if (host_din[2]) ovf_d = 1'b0;
      endcase
    end

    if (push) begin
      fifo_d[wr_q] = {ptr_q, host_din};
      wr_d         = wr_q + AW'(1);
    end

    if (pop) begin
      waddr_d = fifo_q[rd_q][20:8];
      wdata_d = fifo_q[rd_q][7:0];
      rd_d    = rd_q + AW'(1);
    end

    if (flush) begin
      cnt_d = '0;
      wr_d  = '0;
      rd_d  = '0;
    end else if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      fifo_q  <= fifo_d;
    end
  end

endmodule

// File: tb/tb_vram_host_ctrl.sv
// tb/tb_vram_host_ctrl.sv - directed and randomized checks of vram_host_ctrl against a queue-based model
module tb_vram_host_ctrl;
  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;
  localparam int GUARD    = 8;
  localparam int DEPTH    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_cs = 1'b0;
  logic        host_we = 1'b0;
  logic [1:0]  host_rs = 2'd0;
  logic [7:0]  host_din = 8'h00;
  logic [7:0]  host_dout;
  logic [9:0]  posx = 10'd0;
  logic [8:0]  posy = 9'd0;
  logic [12:0] disp_addr = 13'h0ABC;
  logic [12:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        fifo_full;

  vram_host_ctrl #(
    .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE),
    .V_TOTAL(V_TOTAL), .GUARD(GUARD), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .host_cs(host_cs), .host_we(host_we),
    .host_rs(host_rs), .host_din(host_din), .host_dout(host_dout),
    .posx(posx), .posy(posy), .disp_addr(disp_addr), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_we(mem_we), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [20:0] q[$];
  logic [12:0] m_ptr;
  logic        m_ovf;
  logic        exp_we;
  logic [12:0] exp_addr;
  logic [7:0]  exp_din;
  logic [7:0]  exp_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit win_ref(input int x, input int y);
    if (y < V_ACTIVE) return (x >= H_ACTIVE) && (x < H_TOTAL - GUARD);
    return !((y == V_TOTAL - 1) && (x >= H_TOTAL - GUARD));
  endfunction

  task automatic model_reset();
    q.delete();
    m_ptr    = '0;
    m_ovf    = 1'b0;
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_din  = '0;
    exp_dout = '0;
  endtask

  task automatic model_step();
    int n0;
    bit flush;
    logic [20:0] e;
    n0    = q.size();
    flush = host_cs && host_we && (host_rs == 2'd3) && host_din[0];
    if (host_cs && !host_we) begin
      case (host_rs)
        2'd0: exp_dout = m_ptr[7:0];
        2'd1: exp_dout = {3'b000, m_ptr[12:8]};
        2'd2: exp_dout = 8'h00;
        default: exp_dout = {5'b00000, m_ovf, n0 == DEPTH, n0 == 0};
      endcase
    end
    exp_we = 1'b0;
    if (win_ref(int'(posx), int'(posy)) && n0 > 0 && !flush) begin
      e        = q.pop_front();
      exp_we   = 1'b1;
      exp_addr = e[20:8];
      exp_din  = e[7:0];
    end
    if (host_cs && host_we) begin
      case (host_rs)
        2'd0: m_ptr[7:0]  = host_din;
        2'd1: m_ptr[12:8] = host_din[4:0];
        2'd2: begin
          if (n0 < DEPTH) begin
            q.push_back({m_ptr, host_din});
            m_ptr = m_ptr + 13'd1;
          end else begin
            m_ovf = 1'b1;
          end
        end
        default: begin
          if (host_din[0]) q.delete();
          if (host_din[2]) m_ovf = 1'b0;
        end
      endcase
    end
  endtask

  task automatic check_outputs();
    check("mem_we", mem_we, exp_we);
    check("mem_addr", mem_addr, exp_we ? exp_addr : disp_addr);
    check("mem_din", mem_din, exp_din);
    check("host_dout", host_dout, exp_dout);
    check("fifo_full", fifo_full, q.size() == DEPTH);
  endtask

  task automatic advance_pos();
    int x, y;
    x = int'(posx) + 1;
    y = int'(posy);
    if (x == H_TOTAL) begin
      x = 0;
      y = (y == V_TOTAL - 1) ? 0 : y + 1;
    end
    posx = 10'(x);
    posy = 9'(y);
  endtask

  task automatic set_pos(input int x, input int y);
    posx = 10'(x);
    posy = 9'(y);
  endtask

  task automatic cyc(input bit cs, input bit we, input logic [1:0] rs, input logic [7:0] din);
    host_cs   = cs;
    host_we   = we;
    host_rs   = rs;
    host_din  = din;
    disp_addr = 13'($urandom);
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    advance_pos();
  endtask

  task automatic wr(input logic [1:0] rs, input logic [7:0] din);
    cyc(1'b1, 1'b1, rs, din);
  endtask

  task automatic rd(input logic [1:0] rs);
    cyc(1'b1, 1'b0, rs, 8'h00);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  initial begin
    int wcount;
    int guard;
    int r;

    model_reset();
    #1;
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_dout", host_dout, 8'h00);
    check("rst_full", fifo_full, 1'b0);
    check("rst_mem_din", mem_din, 8'h00);
    check("rst_mem_addr", mem_addr, 13'h0ABC);
    @(posedge clk);
    #1;
    rst = 1'b0;

    set_pos(100, 10);
    wr(2'd1, 8'h1F);
    wr(2'd0, 8'hFE);
    wr(2'd2, 8'h41);
    wr(2'd2, 8'h42);
    wr(2'd2, 8'h43);
    check("active_no_we", mem_we, 1'b0);
    rd(2'd3);
    check("status_pending", host_dout, 8'h00);
    rd(2'd0);
    check("ptr_lo_wrap", host_dout, 8'h01);
    rd(2'd1);
    check("ptr_hi_wrap", host_dout, 8'h00);

    set_pos(640, 10);
    idle();
    check("drain0_we", mem_we, 1'b1);
    check("drain0_addr", mem_addr, 13'h1FFE);
    check("drain0_din", mem_din, 8'h41);
    idle();
    check("drain1_addr", mem_addr, 13'h1FFF);
    check("drain1_din", mem_din, 8'h42);
    idle();
    check("drain2_addr", mem_addr, 13'h0000);
    check("drain2_din", mem_din, 8'h43);
    idle();
    check("drain_done_we", mem_we, 1'b0);
    rd(2'd3);
    check("status_empty", host_dout, 8'h01);

    set_pos(0, 20);
    for (int i = 0; i < 9; i++) begin
      wr(2'd2, 8'(8'h60 + i));
      if (i == 6) check("full_after7", fifo_full, 1'b0);
      if (i == 7) check("full_after8", fifo_full, 1'b1);
    end
    rd(2'd3);
    check("status_ovf_full", host_dout, 8'h06);
    rd(2'd0);
    check("ptr_plus8", host_dout, 8'h09);
    wr(2'd3, 8'h04);
    rd(2'd3);
    check("status_ovf_clr", host_dout, 8'h02);
    wr(2'd3, 8'h01);
    rd(2'd3);
    check("status_flushed", host_dout, 8'h01);

    set_pos(H_TOTAL - GUARD, 100);
    for (int i = 0; i < 8; i++) wr(2'd2, 8'($urandom));
    wcount = 0;
    guard  = 0;
    while (!(posy == 9'd101 && posx == 10'd640) && guard < 2000) begin
      idle();
      if (mem_we) wcount++;
      guard++;
    end
    check("guard_hold", wcount, 0);
    check("guard_wait_bound", guard < 2000, 1'b1);
    wcount = 0;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (mem_we) wcount++;
    end
    check("line101_drain", wcount, 8);

    set_pos(H_TOTAL - GUARD, V_TOTAL - 1);
    wr(2'd2, 8'h77);
    wcount = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (mem_we) wcount++;
    end
    check("last_line_guard", wcount, 0);
    wr(2'd3, 8'h01);

    set_pos(0, 40);
    for (int i = 0; i < 8; i++) wr(2'd2, 8'($urandom));
    set_pos(H_TOTAL - GUARD - 4, 40);
    wcount = 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (mem_we) wcount++;
    end
    check("guard_edge_count", wcount, 4);
    wr(2'd3, 8'h01);

    set_pos(0, 100);
    wr(2'd1, 8'h02);
    wr(2'd0, 8'h00);
    wr(2'd2, 8'hA0);
    set_pos(650, 100);
    wr(2'd2, 8'hA1);
    check("pushpop_we", mem_we, 1'b1);
    check("pushpop_addr0", mem_addr, 13'h0200);
    check("pushpop_din0", mem_din, 8'hA0);
    idle();
    check("pushpop_addr1", mem_addr, 13'h0201);
    check("pushpop_din1", mem_din, 8'hA1);
    idle();
    check("pushpop_done", mem_we, 1'b0);

    set_pos(0, 100);
    for (int i = 0; i < 6; i++) wr(2'd2, 8'(8'hB0 + i));
    set_pos(650, 100);
    idle();
    idle();
    wr(2'd3, 8'h01);
    check("flush_we_drop", mem_we, 1'b0);
    rd(2'd3);
    check("flush_status", host_dout, 8'h01);

    set_pos(0, 100);
    wr(2'd0, 8'h55);
    for (int i = 0; i < 4; i++) wr(2'd2, 8'(8'hC0 + i));
    rd(2'd0);
    check("pre_rst_dout", host_dout, 8'h59);
    set_pos(650, 100);
    idle();
    check("pre_rst_we", mem_we, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_we", mem_we, 1'b0);
    check("async_rst_dout", host_dout, 8'h00);
    check("async_rst_addr", mem_addr, disp_addr);
    check("async_rst_full", fifo_full, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd(2'd3);
    check("post_rst_status", host_dout, 8'h01);
    rd(2'd0);
    check("post_rst_ptr", host_dout, 8'h00);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0)
        set_pos(int'($urandom_range(0, H_TOTAL - 1)), int'($urandom_range(0, V_TOTAL - 1)));
      r = int'($urandom_range(0, 9));
      if (r < 3) idle();
      else if (r < 7) wr(2'd2, 8'($urandom));
      else cyc(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
